// File: rtl/trap_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_irq_ctrl_pkg
//   Shared types and constants for the trap/interrupt controller:
//   - trap_state_e : controller FSM states
//   - CAUSE_ECALL_M: mcause code for an environment call from M-mode
//   - irq_flag_bit : position of the interrupt flag inside mcause
//   - idx_width    : width of an interrupt index for a given source count
// -----------------------------------------------------------------------------
package trap_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    IN_TRAP = 2'd2,
    RET     = 2'd3
  } trap_state_e;

  localparam int CAUSE_ECALL_M = 11;

  // The interrupt flag lives in the MSB of mcause.
  function automatic int irq_flag_bit(input int xlen);
    return xlen - 1;
  endfunction

  // A single source still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int num_irq);
    return (num_irq > 1) ? $clog2(num_irq) : 1;
  endfunction

endpackage

// File: rtl/trap_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_irq_ctrl_if
//   Bundle between the core (master) and the trap/interrupt controller (slave).
//   master drives : irq_in, ecall, trap_ret, commit_ok, cur_pc,
//                   ie_we/ie_din, mtvec_we/mtvec_din
//   slave drives  : trapping, trigger_trap, trigger_trap_ret, trap_pc,
//                   mepc, mcause, ip, ie, trap_err
// -----------------------------------------------------------------------------
interface trap_irq_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 8
);

  logic [NUM_IRQ-1:0] irq_in;
  logic               ecall;
  logic               trap_ret;
  logic               commit_ok;
  logic [XLEN-1:0]    cur_pc;
  logic               ie_we;
  logic [NUM_IRQ-1:0] ie_din;
  logic               mtvec_we;
  logic [XLEN-1:0]    mtvec_din;

  logic               trapping;
  logic               trigger_trap;
  logic               trigger_trap_ret;
  logic [XLEN-1:0]    trap_pc;
  logic [XLEN-1:0]    mepc;
  logic [XLEN-1:0]    mcause;
  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] ie;
  logic               trap_err;

  modport master (
    output irq_in, ecall, trap_ret, commit_ok, cur_pc,
           ie_we, ie_din, mtvec_we, mtvec_din,
    input  trapping, trigger_trap, trigger_trap_ret, trap_pc,
           mepc, mcause, ip, ie, trap_err
  );

  modport slave (
    input  irq_in, ecall, trap_ret, commit_ok, cur_pc,
           ie_we, ie_din, mtvec_we, mtvec_din,
    output trapping, trigger_trap, trigger_trap_ret, trap_pc,
           mepc, mcause, ip, ie, trap_err
  );

endinterface

// File: rtl/trap_irq_ctrl_irq_pending.sv
// -----------------------------------------------------------------------------
// trap_irq_ctrl_irq_pending
//   Pending bit for one interrupt source.
//   EDGE=0 : level source, ip follows irq one cycle later; clr has no effect.
//   EDGE=1 : rising-edge source, ip is set on a 0->1 of irq and held until
//            clr (the source is being taken); a new edge wins over clr.
// Ports
//   clk, Rst : clock, synchronous active-high reset
//   irq      : raw request, already synchronous to clk
//   clr      : take of this source
//   ip       : pending bit
// -----------------------------------------------------------------------------
module trap_irq_ctrl_irq_pending #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic Rst,
  input  logic irq,
  input  logic clr,
  output logic ip
);

  if (EDGE) begin : g_edge
    logic irq_prev;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (Rst) begin
        irq_prev <= 1'b0;
        ip       <= 1'b0;
      end else begin
        irq_prev <= irq;
        if (irq && !irq_prev) begin
          ip <= 1'b1;
        end else if (clr) begin
          ip <= 1'b0;
        end
      end
    end
  end else begin : g_level
    logic unused_clr;
    assign unused_clr = clr;

    always_ff @(posedge clk) begin
      if (Rst) begin
        ip <= 1'b0;
      end else begin
        ip <= irq;
      end
    end
  end

endmodule

// File: rtl/trap_irq_ctrl.sv
// -----------------------------------------------------------------------------
// trap_irq_ctrl
//   Trap/interrupt controller for the Mini-RISC-V core. Arbitrates ecall
//   (highest priority) against NUM_IRQ external sources (lowest index wins),
//   captures mepc/mcause on take, and issues one-cycle trigger_trap /
//   trigger_trap_ret pulses with the redirect PC in trap_pc.
// Ports
//   clk  : system clock
//   Rst  : synchronous active-high reset (aborts any trap in progress)
//   bus  : trap_irq_ctrl_if.slave (request inputs, CSR writes, trap outputs)
// -----------------------------------------------------------------------------
module trap_irq_ctrl
  import trap_irq_ctrl_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter int               NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter bit               VECTORED  = 1'b1,
  parameter logic [XLEN-1:0]  RESET_VEC = '0
) (
  input logic           clk,
  input logic           Rst,
  trap_irq_ctrl_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_IRQ);
  localparam int FLAG  = irq_flag_bit(XLEN);

  trap_state_e        state, state_next;

  logic [NUM_IRQ-1:0] ip_q;
  logic [NUM_IRQ-1:0] ie_q;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] active;
  logic               irq_hit;
  logic [IDX_W-1:0]   irq_idx;
  logic               take;
  logic               take_irq;

  logic [XLEN-1:0]    mtvec_q;
  logic [XLEN-1:0]    mepc_q;
  logic [XLEN-1:0]    mcause_q;
  logic               trap_err_q;
  logic               taken_irq_q;
  logic [IDX_W-1:0]   taken_idx_q;

  logic               trapping;
  logic               trigger_trap;
  logic               trigger_trap_ret;
  logic [XLEN-1:0]    trap_pc;
  logic [XLEN-1:0]    irq_cause;
  logic [XLEN-1:0]    vec_offset;

  // ---------------------------------------------------------------------------
  // Per-source pending capture
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_src
    assign clr[k] = take_irq && (irq_idx == IDX_W'(k));

    trap_irq_ctrl_irq_pending #(
      .EDGE (EDGE_MASK[k])
    ) u_pending (
      .clk (clk),
      .Rst (Rst),
      .irq (bus.irq_in[k]),
      .clr (clr[k]),
      .ip  (ip_q[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Priority encoder: registered ie, so an ie write this cycle affects the next.
  // Scanning downwards leaves the lowest enabled pending index in irq_idx.
  // ---------------------------------------------------------------------------
  assign active = ip_q & ie_q;

  // NOTE: every signal written in an always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (active[k]) begin
        irq_hit = 1'b1;
        irq_idx = IDX_W'(k);
      end
    end
  end

  // Take is decided in IDLE; the pulse appears in TAKE, one cycle later.
  assign take     = (state == IDLE) && bus.commit_ok && (bus.ecall || irq_hit);
  assign take_irq = take && !bus.ecall;

  assign irq_cause  = {1'b1, {(FLAG - IDX_W){1'b0}}, irq_idx};
  assign vec_offset = {{(XLEN - IDX_W - 2){1'b0}}, taken_idx_q, 2'b00};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    trapping         = 1'b0;
    trigger_trap     = 1'b0;
    trigger_trap_ret = 1'b0;
    trap_pc          = '0;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_next = TAKE;
        end
      end
      TAKE: begin
        trigger_trap = 1'b1;
        trapping     = 1'b1;
        trap_pc      = (VECTORED && taken_irq_q) ? (mtvec_q + vec_offset) : mtvec_q;
        state_next   = IN_TRAP;
      end
      IN_TRAP: begin
        trapping = 1'b1;
        if (bus.trap_ret) begin
          state_next = RET;
        end
      end
      RET: begin
        trigger_trap_ret = 1'b1;
        trap_pc          = mepc_q;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // CSR-side registers and captured trap state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Rst) begin
      ie_q        <= '0;
      mtvec_q     <= RESET_VEC;
      mepc_q      <= '0;
      mcause_q    <= '0;
      trap_err_q  <= 1'b0;
      taken_irq_q <= 1'b0;
      taken_idx_q <= '0;
    end else begin
      if (bus.ie_we) begin
        ie_q <= bus.ie_din;
      end
      if (bus.mtvec_we) begin
        // mtvec is word aligned; the mode bits are not stored.
        mtvec_q <= bus.mtvec_din & ~XLEN'(3);
      end
      if (take) begin
        mepc_q      <= bus.cur_pc;
        mcause_q    <= bus.ecall ? XLEN'(CAUSE_ECALL_M) : irq_cause;
        taken_irq_q <= !bus.ecall;
        taken_idx_q <= irq_idx;
      end
      // No nesting: an ecall inside the handler is only flagged.
      if ((state == IN_TRAP) && bus.ecall) begin
        trap_err_q <= 1'b1;
      end
    end
  end

  assign bus.trapping         = trapping;
  assign bus.trigger_trap     = trigger_trap;
  assign bus.trigger_trap_ret = trigger_trap_ret;
  assign bus.trap_pc          = trap_pc;
  assign bus.mepc             = mepc_q;
  assign bus.mcause           = mcause_q;
  assign bus.ip               = ip_q;
  assign bus.ie               = ie_q;
  assign bus.trap_err         = trap_err_q;

endmodule

// File: tb/tb_trap_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_irq_ctrl
//   Table of directed vectors, hand-written multi-cycle sequences and random
//   stimulus, all compared every cycle against a behavioural model of the
//   controller's rules. Sources 4..7 are edge-captured, 0..3 level.
// -----------------------------------------------------------------------------
module tb_trap_irq_ctrl;

  localparam int         XLEN      = 32;
  localparam int         NUM_IRQ   = 8;
  localparam logic [7:0] EDGE_MASK = 8'hF0;

  logic clk;
  logic rst;

  trap_irq_ctrl_if #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) bus ();

  trap_irq_ctrl #(
    .XLEN      (XLEN),
    .NUM_IRQ   (NUM_IRQ),
    .EDGE_MASK (EDGE_MASK),
    .VECTORED  (1'b1),
    .RESET_VEC (32'h0)
  ) dut (
    .clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: handler activity as flags, pending as a bit array,
  // priority by scanning indices, redirect target by arithmetic.
  // ---------------------------------------------------------------------------
  bit        m_take, m_ret, m_in, m_err;
  bit [7:0]  m_ip, m_prev, m_ie;
  bit [31:0] m_mtvec, m_mepc, m_mcause;
  int        m_vidx;

  function automatic int winner();
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (m_ip[k] && m_ie[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit old_take, old_ret, old_in, idle, take;
    int w;
    old_take = m_take;
    old_ret  = m_ret;
    old_in   = m_in;
    if (rst) begin
      m_take = 0; m_ret = 0; m_in = 0; m_err = 0;
      m_ip = '0; m_prev = '0; m_ie = '0;
      m_mtvec = 32'h0; m_mepc = '0; m_mcause = '0; m_vidx = 0;
      return;
    end
    w      = winner();
    idle   = !old_in && !old_ret;
    take   = idle && bus.commit_ok && (bus.ecall || w >= 0);
    m_take = take;
    m_ret  = old_in && !old_take && bus.trap_ret;
    m_in   = take || (old_in && !m_ret);
    if (old_in && !old_take && bus.ecall) m_err = 1;
    if (take) begin
      m_mepc = bus.cur_pc;
      if (bus.ecall) begin
        m_mcause = 32'd11;
        m_vidx   = 0;
      end else begin
        m_mcause = 32'h8000_0000 + 32'(w);
        m_vidx   = w;
      end
    end
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (EDGE_MASK[k]) begin
        if (bus.irq_in[k] && !m_prev[k]) m_ip[k] = 1'b1;
        else if (take && !bus.ecall && w == k) m_ip[k] = 1'b0;
      end else begin
        m_ip[k] = bus.irq_in[k];
      end
    end
    m_prev = bus.irq_in;
    if (bus.ie_we)    m_ie    = bus.ie_din;
    if (bus.mtvec_we) m_mtvec = bus.mtvec_din & 32'hFFFF_FFFC;
  endtask

  // One clock: inputs already driven, sample 1 time unit after the edge.
  task automatic cyc();
    logic [31:0] exp_pc;
    @(posedge clk);
    #1;
    model_step();
    exp_pc = m_take ? (m_mtvec + 32'(4 * m_vidx)) : (m_ret ? m_mepc : 32'h0);
    check("trigger_trap",     32'(bus.trigger_trap),     32'(m_take));
    check("trigger_trap_ret", 32'(bus.trigger_trap_ret), 32'(m_ret));
    check("trapping",         32'(bus.trapping),         32'(m_in));
    check("trap_pc",          bus.trap_pc,               exp_pc);
    check("mepc",             bus.mepc,                  m_mepc);
    check("mcause",           bus.mcause,                m_mcause);
    check("ip",               32'(bus.ip),               32'(m_ip));
    check("ie",               32'(bus.ie),               32'(m_ie));
    check("trap_err",         32'(bus.trap_err),         32'(m_err));
  endtask

  task automatic quiet_inputs();
    rst           = 1'b0;
    bus.ecall     = 1'b0;
    bus.trap_ret  = 1'b0;
    bus.commit_ok = 1'b0;
    bus.irq_in    = '0;
    bus.ie_we     = 1'b0;
    bus.ie_din    = '0;
    bus.mtvec_we  = 1'b0;
    bus.mtvec_din = '0;
  endtask

  // Leave a freshly taken trap: ret ignored in TAKE, honoured in IN_TRAP.
  task automatic leave_trap();
    quiet_inputs();
    bus.trap_ret = 1'b1;
    cyc();
    cyc();
    bus.trap_ret = 1'b0;
    cyc();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          rst, ecall, tret, cok;
    logic [7:0]  irq;
    logic [31:0] pc;
    bit          iew;
    logic [7:0]  ied;
    bit          mtw;
    logic [31:0] mtd;
    bit          e_tt, e_tr, e_trapping;
    logic [31:0] e_pc, e_mepc, e_mcause;
  } vec_t;

  function automatic vec_t mk(bit r, bit ec, bit tr, bit ck, logic [7:0] irq, logic [31:0] pc,
                              bit iew, logic [7:0] ied, bit mtw, logic [31:0] mtd,
                              bit e_tt, bit e_tr, bit e_tp, logic [31:0] e_pc,
                              logic [31:0] e_mepc, logic [31:0] e_mcause);
    vec_t v;
    v.rst = r; v.ecall = ec; v.tret = tr; v.cok = ck; v.irq = irq; v.pc = pc;
    v.iew = iew; v.ied = ied; v.mtw = mtw; v.mtd = mtd;
    v.e_tt = e_tt; v.e_tr = e_tr; v.e_trapping = e_tp;
    v.e_pc = e_pc; v.e_mepc = e_mepc; v.e_mcause = e_mcause;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    quiet_inputs();
    bus.cur_pc = '0;

    //            rst ec tr ck irq    pc         iew ied    mtw mtd        tt tr tp pc          mepc   mcause
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 32'h00, 0, 8'h00, 0, 32'h000, 0, 0, 0, 32'h000, 32'h00, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 32'h00, 1, 8'h05, 1, 32'h103, 0, 0, 0, 32'h000, 32'h00, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h00, 32'h40, 0, 8'h00, 0, 32'h000, 1, 0, 1, 32'h100, 32'h40, 32'd11));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 32'h44, 0, 8'h00, 0, 32'h000, 0, 0, 1, 32'h000, 32'h40, 32'd11));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 32'h44, 0, 8'h00, 0, 32'h000, 0, 1, 0, 32'h040, 32'h40, 32'd11));
    vecs.push_back(mk(0, 0, 0, 0, 8'h06, 32'h80, 0, 8'h00, 0, 32'h000, 0, 0, 0, 32'h000, 32'h40, 32'd11));
    vecs.push_back(mk(0, 0, 0, 1, 8'h06, 32'h80, 0, 8'h00, 0, 32'h000, 1, 0, 1, 32'h108, 32'h80, 32'h8000_0002));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 32'h84, 0, 8'h00, 0, 32'h000, 0, 0, 1, 32'h000, 32'h80, 32'h8000_0002));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 32'h84, 0, 8'h00, 0, 32'h000, 0, 1, 0, 32'h080, 32'h80, 32'h8000_0002));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 32'h88, 0, 8'h00, 0, 32'h000, 0, 0, 0, 32'h000, 32'h80, 32'h8000_0002));

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.ecall     = vecs[i].ecall;
      bus.trap_ret  = vecs[i].tret;
      bus.commit_ok = vecs[i].cok;
      bus.irq_in    = vecs[i].irq;
      bus.cur_pc    = vecs[i].pc;
      bus.ie_we     = vecs[i].iew;
      bus.ie_din    = vecs[i].ied;
      bus.mtvec_we  = vecs[i].mtw;
      bus.mtvec_din = vecs[i].mtd;
      cyc();
      check($sformatf("vec%0d.trigger_trap", i),     32'(bus.trigger_trap),     32'(vecs[i].e_tt));
      check($sformatf("vec%0d.trigger_trap_ret", i), 32'(bus.trigger_trap_ret), 32'(vecs[i].e_tr));
      check($sformatf("vec%0d.trapping", i),         32'(bus.trapping),         32'(vecs[i].e_trapping));
      check($sformatf("vec%0d.trap_pc", i),          bus.trap_pc,               vecs[i].e_pc);
      check($sformatf("vec%0d.mepc", i),             bus.mepc,                  vecs[i].e_mepc);
      check($sformatf("vec%0d.mcause", i),           bus.mcause,                vecs[i].e_mcause);
    end

    // --- ecall and irq0 together: ecall first, irq0 after the return -------
    quiet_inputs();
    bus.ie_we = 1'b1; bus.ie_din = 8'h01; bus.irq_in = 8'h01;
    cyc();
    bus.ie_we = 1'b0; bus.ecall = 1'b1; bus.commit_ok = 1'b1; bus.cur_pc = 32'h200;
    cyc();
    check("both.take_ecall", bus.mcause, 32'd11);
    bus.ecall = 1'b0;
    cyc();
    check("both.irq0_pending", 32'(bus.ip[0]), 32'd1);
    bus.trap_ret = 1'b1;
    cyc();
    check("both.ret_pulse", 32'(bus.trigger_trap_ret), 32'd1);
    bus.trap_ret = 1'b0;
    cyc();
    check("both.no_take_in_ret", 32'(bus.trigger_trap), 32'd0);
    cyc();
    check("both.irq0_taken", 32'(bus.trigger_trap), 32'd1);
    check("both.irq0_cause", bus.mcause, 32'h8000_0000);
    check("both.irq0_pc",    bus.trap_pc, 32'h100);
    leave_trap();

    // --- edge source pulsed while in the handler ---------------------------
    bus.ie_we = 1'b1; bus.ie_din = 8'h10;
    cyc();
    bus.ie_we = 1'b0; bus.ecall = 1'b1; bus.commit_ok = 1'b1; bus.cur_pc = 32'h300;
    cyc();
    bus.ecall = 1'b0;
    cyc();
    bus.irq_in = 8'h10;
    cyc();
    bus.irq_in = 8'h00;
    cyc();
    check("edge.held", 32'(bus.ip[4]), 32'd1);
    cyc();
    check("edge.no_nest", 32'(bus.trigger_trap), 32'd0);
    check("edge.still_held", 32'(bus.ip[4]), 32'd1);
    bus.trap_ret = 1'b1;
    cyc();
    bus.trap_ret = 1'b0;
    cyc();
    cyc();
    check("edge.taken", 32'(bus.trigger_trap), 32'd1);
    check("edge.cause", bus.mcause, 32'h8000_0004);
    check("edge.pc", bus.trap_pc, 32'h110);
    check("edge.cleared", 32'(bus.ip[4]), 32'd0);
    leave_trap();

    // --- commit_ok low stalls the take; request is not lost ----------------
    bus.ecall = 1'b1; bus.cur_pc = 32'h400;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall.no_pulse", 32'(bus.trigger_trap), 32'd0);
    end
    bus.commit_ok = 1'b1;
    cyc();
    check("stall.pulse", 32'(bus.trigger_trap), 32'd1);
    check("stall.mepc", bus.mepc, 32'h400);

    // --- ecall in handler -> trap_err; reset mid-trap ----------------------
    bus.ecall = 1'b0;
    cyc();
    bus.ecall = 1'b1;
    cyc();
    check("err.set", 32'(bus.trap_err), 32'd1);
    bus.ecall = 1'b0; bus.ie_we = 1'b1; bus.ie_din = 8'hFF;
    cyc();
    bus.ie_we = 1'b0; rst = 1'b1;
    cyc();
    check("rst.trapping", 32'(bus.trapping), 32'd0);
    check("rst.mepc",     bus.mepc, 32'h0);
    check("rst.ie",       32'(bus.ie), 32'h0);
    check("rst.trap_err", 32'(bus.trap_err), 32'd0);
    rst = 1'b0; bus.trap_ret = 1'b1;
    cyc();
    check("rst.ret_ignored", 32'(bus.trigger_trap_ret), 32'd0);

    // --- randomized traffic against the model ------------------------------
    quiet_inputs();
    for (int i = 0; i < 2000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.ecall     = ($urandom_range(0, 9) == 0);
      bus.trap_ret  = ($urandom_range(0, 4) == 0);
      bus.commit_ok = ($urandom_range(0, 9) < 7);
      bus.irq_in    = bus.irq_in ^ 8'($urandom & $urandom & $urandom);
      bus.cur_pc    = {$urandom_range(0, 32'h3FFF), 2'b00};
      bus.ie_we     = ($urandom_range(0, 19) == 0);
      bus.ie_din    = 8'($urandom);
      bus.mtvec_we  = ($urandom_range(0, 29) == 0);
      bus.mtvec_din = $urandom & 32'h0000_FFFF;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
